// File: rtl/pwm_pkg.sv
// pwm_pkg: shared duty-code constants and capture FSM encoding
package pwm_pkg;
  localparam int DUTY_W = 10;
  localparam logic [DUTY_W-1:0] DUTY_MAX = 10'd1023;
  localparam int TIMEOUT_DEF = 16384;
  typedef enum logic [1:0] {ST_IDLE, ST_MEASURE, ST_TIMED_OUT} state_e;
endpackage

// File: rtl/pwm_duty_div.sv
// pwm_duty_div: 11-step restoring divide giving floor(num*1024/den), saturated to 1023
module pwm_duty_div
  import pwm_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  num,
  input  logic [CNT_W-1:0]  den,
  output logic              busy,
  output logic              done,
  output logic [DUTY_W-1:0] q
);
  logic [CNT_W:0] rem_q;
  logic [CNT_W-1:0] den_q;
  logic [DUTY_W-1:0] quo_q;
  logic [3:0] cnt_q;
  logic ge;
  logic [CNT_W-1:0] diff;
  logic [DUTY_W:0] quo_d;
  // num carries ten implicit zero LSBs, fed in one per step by the remainder shift
  always_comb begin
    ge = rem_q >= {1'b0, den_q};
    diff = ge ? CNT_W'(rem_q - {1'b0, den_q}) : rem_q[CNT_W-1:0];
    quo_d = {quo_q, ge};
    busy = cnt_q != 4'd0;
    done = cnt_q == 4'd1;
    q = quo_d[DUTY_W] ? DUTY_MAX : quo_d[DUTY_W-1:0];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_q <= '0;
      den_q <= '0;
      quo_q <= '0;
      cnt_q <= 4'd0;
    end else if (start) begin
      rem_q <= {1'b0, num};
      den_q <= den;
      quo_q <= '0;
      cnt_q <= 4'd11;
    end else if (busy) begin
      rem_q <= {diff, 1'b0};
      quo_q <= quo_d[DUTY_W-1:0];
      cnt_q <= cnt_q - 4'd1;
    end
  end
endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures period, high time and 10-bit duty code of an asynchronous PWM line
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pwm_in,
  output logic [CNT_W-1:0]  period,
  output logic [CNT_W-1:0]  high_time,
  output logic [DUTY_W-1:0] duty,
  output logic              valid,
  output logic              timeout,
  output logic              overrun
);
  state_e state_q;
  logic [1:0] sync_q;
  logic s_prev_q;
  logic [CNT_W-1:0] per_cnt_q, hi_cnt_q, period_q, high_q;
  logic [DUTY_W-1:0] duty_q;
  logic valid_q, timeout_q, overrun_q;
  logic s, rise, expire, div_start, div_busy, div_done;
  logic [DUTY_W-1:0] div_q;
  logic [CNT_W-1:0] per_inc, hi_inc;
  always_comb begin
    s = sync_q[1];
    rise = s & ~s_prev_q;
    expire = state_q != ST_TIMED_OUT && !rise && per_cnt_q >= CNT_W'(TIMEOUT);
    div_start = rise && state_q == ST_MEASURE && !div_busy;
    per_inc = &per_cnt_q ? per_cnt_q : per_cnt_q + CNT_W'(1);
    hi_inc = &hi_cnt_q ? hi_cnt_q : hi_cnt_q + CNT_W'(1);
  end
  pwm_duty_div #(.CNT_W(CNT_W)) u_div (
    .clk   (clk),
    .rst   (rst),
    .start (div_start),
    .num   (hi_cnt_q),
    .den   (per_cnt_q),
    .busy  (div_busy),
    .done  (div_done),
    .q     (div_q)
  );
  // a timeout report pre-empts any divide result landing in the same cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      sync_q <= 2'b00;
      s_prev_q <= 1'b0;
      per_cnt_q <= '0;
      hi_cnt_q <= '0;
      period_q <= '0;
      high_q <= '0;
      duty_q <= '0;
      valid_q <= 1'b0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], pwm_in};
      s_prev_q <= s;
      valid_q <= 1'b0;
      if (expire) begin
        state_q <= ST_TIMED_OUT;
        period_q <= '0;
        high_q <= '0;
        duty_q <= s ? DUTY_MAX : '0;
        timeout_q <= 1'b1;
        valid_q <= 1'b1;
      end else if (rise) begin
        state_q <= ST_MEASURE;
        timeout_q <= 1'b0;
        per_cnt_q <= CNT_W'(1);
        hi_cnt_q <= CNT_W'(1);
        if (div_start) begin
          period_q <= per_cnt_q;
          high_q <= hi_cnt_q;
        end
        if (state_q == ST_MEASURE && div_busy) overrun_q <= 1'b1;
      end else if (state_q != ST_TIMED_OUT) begin
        per_cnt_q <= per_inc;
        if (s) hi_cnt_q <= hi_inc;
      end
      if (div_done && state_q == ST_MEASURE && !expire) begin
        duty_q <= div_q;
        valid_q <= 1'b1;
      end
    end
  end
  assign period = period_q;
  assign high_time = high_q;
  assign duty = duty_q;
  assign valid = valid_q;
  assign timeout = timeout_q;
  assign overrun = overrun_q;
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: table vectors, corner sequences and random waveforms against an event-level model
module tb_pwm_capture;
  localparam int TMO = 16384;
  localparam int MAXN = 17000;
  localparam int RN = 12000;
  typedef struct packed {
    int          cyc;
    logic [31:0] per;
    logic [31:0] hi;
    logic [9:0]  duty;
    logic        to;
  } ev_t;
  typedef struct {
    int per, hi, n, e_per, e_hi, e_duty, e_to, e_cyc;
  } vec_t;
  logic clk, rst, pwm_in, valid, timeout, overrun;
  logic [31:0] period, high_time;
  logic [9:0] duty;
  bit w [MAXN];
  logic tout_tr [MAXN];
  logic ovr_tr [MAXN];
  ev_t act_q[$], exp_q[$];
  bit exp_ovr;
  int tests, fails, xcnt;
  vec_t tbl [10];

  pwm_capture dut (
    .clk       (clk),
    .rst       (rst),
    .pwm_in    (pwm_in),
    .period    (period),
    .high_time (high_time),
    .duty      (duty),
    .valid     (valid),
    .timeout   (timeout),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic string fmt(input ev_t e);
    return $sformatf("cyc=%0d per=%0d hi=%0d duty=%0d to=%0b", e.cyc, e.per, e.hi, e.duty, e.to);
  endfunction

  function automatic bit sv(input int j);
    return (j >= 2) ? w[j-2] : 1'b0;
  endfunction

  task automatic check(input string name, input bit ok, input string got, input string want);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %s, expected %s", name, got, want);
    end
  endtask

  task automatic clear_w();
    for (int k = 0; k < MAXN; k++) w[k] = 1'b0;
  endtask

  task automatic fill_periodic(input int per, input int hi, input int from, input int upto);
    for (int k = from; k <= upto && k < MAXN; k++) w[k] = ((k - from) % per) < hi;
  endtask

  task automatic begin_run();
    rst = 1'b0;
    pwm_in = w[0];
    act_q.delete();
    xcnt = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic step(input int k);
    @(posedge clk);
    #1 pwm_in = w[k];
    @(negedge clk);
    if (valid === 1'b1) act_q.push_back('{k, period, high_time, duty, timeout});
    tout_tr[k] = timeout;
    ovr_tr[k] = overrun;
    if ($isunknown({period, high_time, duty, valid, timeout, overrun})) xcnt++;
  endtask

  task automatic run_wave(input int n);
    begin_run();
    for (int k = 1; k <= n; k++) step(k);
  endtask

  // interval j sees synchronized level s[j] = w[j-2]; reports follow the rise/timeout rules directly
  task automatic model(input int n);
    int anchor = 0;
    int acc = -1000;
    int hi;
    bit tout = 0;
    bit idle = 1;
    bit sj, rise;
    longint q;
    exp_q.delete();
    exp_ovr = 0;
    for (int j = 1; j <= n; j++) begin
      sj = sv(j);
      rise = sj && !sv(j-1);
      if (!tout && !rise && j - anchor >= TMO) begin
        if (j + 1 <= n) exp_q.push_back('{j + 1, 32'd0, 32'd0, sj ? 10'd1023 : 10'd0, 1'b1});
        tout = 1;
      end else if (rise) begin
        if (!tout && !idle) begin
          if (j - acc <= 11) begin
            if (j < n) exp_ovr = 1;
          end else begin
            acc = j;
            hi = 0;
            for (int i = anchor; i < j; i++) hi += int'(sv(i));
            q = longint'(hi) * 1024 / longint'(j - anchor);
            if (q > 1023) q = 1023;
            if (j + 12 <= n) exp_q.push_back('{j + 12, 32'(j - anchor), 32'(hi), 10'(q), 1'b0});
          end
        end
        anchor = j;
        tout = 0;
        idle = 0;
      end
    end
  endtask

  task automatic compare_events(input string name, input int n);
    check({name, " count"}, act_q.size() == exp_q.size(),
          $sformatf("%0d", act_q.size()), $sformatf("%0d", exp_q.size()));
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s ev%0d", name, i), act_q[i] === exp_q[i], fmt(act_q[i]), fmt(exp_q[i]));
    check({name, " overrun"}, ovr_tr[n] === exp_ovr, $sformatf("%b", ovr_tr[n]), $sformatf("%b", exp_ovr));
  endtask

  task automatic check_ev(input string name, input int idx, input ev_t want);
    ev_t got;
    got = (act_q.size() > idx) ? act_q[idx] : '0;
    check(name, act_q.size() > idx && got === want, act_q.size() > idx ? fmt(got) : "none", fmt(want));
  endtask

  initial begin
    int k, per, hi, rep, len;
    bit lvl;
    tests = 0;
    fails = 0;
    rst = 1'b0;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    check("reset period", period === 32'd0, $sformatf("%0d", period), "0");
    check("reset high_time", high_time === 32'd0, $sformatf("%0d", high_time), "0");
    check("reset duty", duty === 10'd0, $sformatf("%0d", duty), "0");
    check("reset valid", valid === 1'b0, $sformatf("%b", valid), "0");
    check("reset timeout", timeout === 1'b0, $sformatf("%b", timeout), "0");
    check("reset overrun", overrun === 1'b0, $sformatf("%b", overrun), "0");

    tbl = '{
      '{4001, 2000, 4030, 4001, 2000, 511, 0, 4020},
      '{4001, 3996, 4030, 4001, 3996, 1022, 0, 4020},
      '{100, 25, 130, 100, 25, 256, 0, 119},
      '{50, 49, 80, 50, 49, 1003, 0, 69},
      '{13, 6, 40, 13, 6, 472, 0, 32},
      '{13, 12, 40, 13, 12, 945, 0, 32},
      '{64, 32, 90, 64, 32, 512, 0, 83},
      '{1024, 1023, 1050, 1024, 1023, 1023, 0, 1043},
      '{1000, 1, 1030, 1000, 1, 1, 0, 1019},
      '{100, 0, 16400, 0, 0, 0, 1, 16385}
    };
    foreach (tbl[i]) begin
      clear_w();
      fill_periodic(tbl[i].per, tbl[i].hi, 5, tbl[i].n);
      run_wave(tbl[i].n);
      check_ev($sformatf("vec%0d first", i), 0,
               '{tbl[i].e_cyc, 32'(tbl[i].e_per), 32'(tbl[i].e_hi), 10'(tbl[i].e_duty), 1'(tbl[i].e_to)});
      model(tbl[i].n);
      compare_events($sformatf("vec%0d", i), tbl[i].n);
    end

    // line stuck high long enough to time out, then a 100-cycle / 25-high waveform resumes
    clear_w();
    for (int j = 5; j < 16600; j++) w[j] = 1'b1;
    for (int j = 16600; j <= 16800; j++) w[j] = ((j - 16600) % 100) >= 75;
    run_wave(16800);
    check_ev("stuck high timeout", 0, '{16392, 32'd0, 32'd0, 10'd1023, 1'b1});
    check("timeout clears on rise", tout_tr[16677] === 1'b1 && tout_tr[16678] === 1'b0,
          $sformatf("%b->%b", tout_tr[16677], tout_tr[16678]), "1->0");
    check_ev("recovered period", 1, '{16789, 32'd100, 32'd25, 10'd256, 1'b0});
    model(16800);
    compare_events("recovery", 16800);

    clear_w();
    fill_periodic(10, 5, 5, 200);
    run_wave(200);
    check("overrun sets", ovr_tr[27] === 1'b0 && ovr_tr[28] === 1'b1,
          $sformatf("%b->%b", ovr_tr[27], ovr_tr[28]), "0->1");
    check("overrun sticky", ovr_tr[200] === 1'b1, $sformatf("%b", ovr_tr[200]), "1");
    check_ev("short period first", 0, '{29, 32'd10, 32'd5, 10'd512, 1'b0});
    model(200);
    compare_events("short period", 200);

    // asynchronous reset pulse in the middle of the first divide
    clear_w();
    fill_periodic(100, 25, 5, 300);
    begin_run();
    for (int j = 1; j <= 111; j++) step(j);
    check("latched before reset", period === 32'd100, $sformatf("%0d", period), "100");
    #2 rst = 1'b0;
    #1 check("async reset clears", {period, high_time, duty, valid, timeout, overrun} === '0,
             $sformatf("%0d/%0d/%0d/%b/%b/%b", period, high_time, duty, valid, timeout, overrun), "all 0");
    #5 rst = 1'b1;
    for (int j = 112; j <= 130; j++) step(j);
    check("no stale valid", act_q.size() == 0, $sformatf("%0d", act_q.size()), "0");

    // one glitch entirely between edges, one straddling an edge (sampled as a single high cycle)
    clear_w();
    fill_periodic(100, 25, 5, 300);
    begin_run();
    for (int j = 1; j <= 300; j++) begin
      step(j);
      if (j == 150) begin
        #1 pwm_in = 1'b1;
        #2 pwm_in = 1'b0;
      end
      if (j == 249) #4 pwm_in = 1'b1;
    end
    check("glitch no X", xcnt == 0, $sformatf("%0d", xcnt), "0");
    w[249] = 1'b1;
    model(300);
    compare_events("glitch", 300);

    clear_w();
    k = 0;
    while (k <= RN) begin
      if ($urandom_range(0, 9) == 0) begin
        lvl = 1'($urandom_range(0, 1));
        len = $urandom_range(20, 300);
        for (int j = 0; j < len && k < MAXN; j++) w[k++] = lvl;
      end else begin
        per = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 12) : $urandom_range(13, 400);
        hi = $urandom_range(1, per - 1);
        rep = $urandom_range(1, 4);
        for (int r = 0; r < rep; r++)
          for (int j = 0; j < per && k < MAXN; j++) w[k++] = j < hi;
      end
    end
    run_wave(RN);
    check("random no X", xcnt == 0, $sformatf("%0d", xcnt), "0");
    model(RN);
    compare_events("random", RN);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pwm_capture.md
# pwm_capture

Measures an incoming PWM waveform and recovers its period, high time and 10-bit duty code (0–1023), matching the duty encoding the motor PWM generators use. It is the receive-side counterpart of the 25 kHz motor PWM path. Uses: loop-back self-test of the motor outputs, and reading external PWM sources (servo/RC receivers) into the car controller. Results are posted as a one-cycle `valid` strobe per completed period, or a timeout report when the line stops toggling.

## Interface
- `CNT_W`, 32: width of period/high-time counters.
- `TIMEOUT`, 16384: clk cycles without a rising edge before a timeout is reported.
- `clk`  in  1  system clock (100 MHz).
- `rst`  in  1  asynchronous, active-low reset.
- `pwm_in`  in  1  PWM line; asynchronous to `clk`.
- `period`  out  CNT_W  last measured period in clk cycles; reset 0.
- `high_time`  out  CNT_W  last measured high time in clk cycles; reset 0.
- `duty`  out  10  `floor(high_time*1024/period)`, saturated to 1023; reset 0.
- `valid`  out  1  one-cycle strobe when `period`/`high_time`/`duty` update; reset 0.
- `timeout`  out  1  level; 1 while no rising edge has been seen for ≥ TIMEOUT cycles; reset 0.
- `overrun`  out  1  sticky; set when a period completes while the divider is busy; cleared only by reset; reset 0.

## Operation
- `pwm_in` passes through a 2-flop synchronizer; `s` is the second-stage output. A rise is detected when `s`=1 and the previous `s`=0; a fall is detected similarly. All counting uses `s`.
- FSM states: IDLE, MEASURE, TIMED_OUT.
  - IDLE (after reset): wait for a rise; on rise, clear counters (`per_cnt`=1, `hi_cnt`=1) → MEASURE.
  - MEASURE: every cycle `per_cnt`+=1; `hi_cnt`+=1 when `s`=1. On a rise: latch `per_cnt`→`period` and `hi_cnt`→`high_time`, start the divider, restart counters at 1. Stay in MEASURE.
  - Any state except TIMED_OUT: if `per_cnt` reaches TIMEOUT with no rise, go to TIMED_OUT. On entry: `period`=0; `high_time`=0; `duty`=1023 if `s`=1, else 0; `timeout`=1; one `valid` pulse.
  - TIMED_OUT: on a rise, `timeout`←0 and restart counters → MEASURE. The first full period after recovery is reported normally.
- Counters saturate at all-ones. They never wrap.
- Divider: restoring, unsigned, 11 iterations (1 per clk). Dividend is `high_time`<<10 and divisor is `period`. Because `high_time` ≤ `period`, the quotient is ≤ 1024. A quotient of 1024 is saturated to 1023. A divisor of 0 cannot occur in MEASURE.
- If a rise arrives while the divider is busy, that period's latched values are discarded, `overrun`←1, and counting continues. Valid input requires period ≥ 13 cycles.
- A timeout during a busy divide aborts the divide; the timeout report wins.
- Reset mid-operation returns every output and state to its reset value immediately (asynchronous).

## Timing
- Input-to-detect latency: 2–3 clk (synchronizer plus edge register).
- Let cycle E be the cycle in which a rise is detected.
  - `period`/`high_time` are registered at E+1.
  - Divider runs E+1..E+11.
  - `duty` updates and `valid`=1 at E+12, for exactly one cycle.
- `period`, `high_time` and `duty` hold until the next `valid`.
- Timeout `valid` is issued in the cycle after `per_cnt` reaches TIMEOUT.

## Structure
- Shared package `pwm_pkg`: DUTY_W=10, DUTY_MAX=1023, the FSM state encoding, default TIMEOUT.
- One sub-module, `pwm_duty_div`:
  - Inputs: `start`, `num`, `den`.
  - Outputs: `busy`, `done`, `q`[9:0] (already saturated).
  - Fixed 11-cycle latency.
- Top level contains: synchronizer, edge detector, FSM, counters, output registers.

## Test plan
- Loop-back against the existing motor PWM generator (period 4001 cycles), duty code 512: each `valid` gives `period`=4001, `high_time`=2000, `duty`=511.
- Same loop-back with duty code 1023: `high_time`=3996, `duty`=1022. With duty code 0 (line stuck low): after 16384 cycles, a single `valid` with `duty`=0, `period`=0, `timeout`=1.
- Line held high for >16384 cycles: `duty`=1023, `timeout`=1. Then resume a 100-cycle period with 25 high: `timeout` clears on the first rise; next `valid` gives `period`=100, `high_time`=25, `duty`=256.
- Period of 10 cycles: `overrun`=1 and stays 1. No `valid` is produced for the dropped periods.
- Drive `rst` low for 1 cycle mid-divide, asynchronous to `clk`: all outputs are 0 immediately, and no stale `valid` appears afterward.
- Check latency: `valid` asserts exactly 12 cycles after the detect cycle. A 1-cycle glitch on `pwm_in` shorter than the clk period is either ignored or counted as exactly one cycle; it never produces X.
